// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : irq_controller
// Purpose  : Edge-latched, mask-gated, fixed-priority interrupt controller
//            presenting a held level interrupt plus source ID to the CPU.
// Revision : 1.0  initial release
// ============================================================================
module irq_controller #(
    parameter int                 NUM_IRQ  = 8,
    parameter int                 ID_W     = 3,
    parameter logic [NUM_IRQ-1:0] MASK_RST = '1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irqIn,
    input  logic [NUM_IRQ-1:0] maskValue,
    input  logic               setMask,
    input  logic               ack,
    output logic               irq,
    output logic [ID_W-1:0]    irqID,
    output logic [NUM_IRQ-1:0] pending
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [NUM_IRQ-1:0] prev;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] clear;
    logic [NUM_IRQ-1:0] pending_next;
    logic [ID_W-1:0]    sel_id;
    logic               irq_next;
    logic [ID_W-1:0]    id_next;

    assign rise     = irqIn & ~prev;
    assign eligible = pending & mask;

    // Descending scan so the lowest eligible index is the last writer.
    always_comb begin
        sel_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_next = state;
        irq_next   = irq;
        id_next    = irqID;
        clear      = '0;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    irq_next   = 1'b1;
                    id_next    = sel_id;
                    state_next = ASSERT;
                end
            end
            ASSERT: begin
                if (ack) begin
                    irq_next   = 1'b0;
                    clear      = NUM_IRQ'(1) << irqID;
                    state_next = HOLDOFF;
                end
            end
            HOLDOFF: begin
                irq_next   = 1'b0;
                state_next = IDLE;
            end
            default: begin
                irq_next   = 1'b0;
                state_next = IDLE;
            end
        endcase
        // A rise in the ack cycle must survive the clear.
        pending_next = (pending & ~clear) | rise;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            irq     <= 1'b0;
            irqID   <= '0;
            pending <= '0;
            mask    <= MASK_RST;
            prev    <= '0;
        end else begin
            state   <= state_next;
            irq     <= irq_next;
            irqID   <= id_next;
            pending <= pending_next;
            prev    <= irqIn;
            if (setMask) begin
                mask <= maskValue;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_controller
// Purpose  : Directed self-checking bench for irq_controller.
// Revision : 1.0  initial release
// ============================================================================
module tb_irq_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irqIn;
    logic [7:0] maskValue;
    logic       setMask;
    logic       ack;
    logic       irq;
    logic [2:0] irqID;
    logic [7:0] pending;

    int checks = 0;
    int errors = 0;

    irq_controller #(
        .NUM_IRQ  (8),
        .ID_W     (3),
        .MASK_RST (8'hFF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irqIn     (irqIn),
        .maskValue (maskValue),
        .setMask   (setMask),
        .ack       (ack),
        .irq       (irq),
        .irqID     (irqID),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; irqIn = '0; maskValue = '0; setMask = 1'b0; ack = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending got %h want 00", pending); end
        checks++; if (irqID !== 3'd0) begin errors++; $display("FAIL reset_id got %0d want 0", irqID); end
        irqIn = 8'h04;
        tick();
        irqIn = 8'h00;
        checks++; if (pending !== 8'h04) begin errors++; $display("FAIL single_pending got %h want 04", pending); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_early_irq got %b want 0", irq); end
        tick();
        checks++; if (irq !== 1'b1 || irqID !== 3'd2) begin errors++; $display("FAIL single_assert got irq=%b id=%0d want irq=1 id=2", irq, irqID); end
        tick(); tick(); tick();
        checks++; if (irq !== 1'b1 || irqID !== 3'd2) begin errors++; $display("FAIL single_hold got irq=%b id=%0d want irq=1 id=2", irq, irqID); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++; if (irq !== 1'b0 || pending !== 8'h00) begin errors++; $display("FAIL single_ack got irq=%b pend=%h want irq=0 pend=00", irq, pending); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_after got irq=%b want 0 (cycle %0d)", irq, i); end
        end
    endtask

    task automatic test_priority();
        do_reset();
        irqIn = 8'h90;
        tick();
        irqIn = 8'h00;
        checks++; if (pending !== 8'h90) begin errors++; $display("FAIL prio_pending got %h want 90", pending); end
        tick();
        checks++; if (irq !== 1'b1 || irqID !== 3'd4) begin errors++; $display("FAIL prio_first got irq=%b id=%0d want irq=1 id=4", irq, irqID); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++; if (irq !== 1'b0 || pending !== 8'h80) begin errors++; $display("FAIL prio_ack1 got irq=%b pend=%h want irq=0 pend=80", irq, pending); end
        tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL prio_holdoff got irq=%b want 0", irq); end
        tick();
        checks++; if (irq !== 1'b1 || irqID !== 3'd7) begin errors++; $display("FAIL prio_second got irq=%b id=%0d want irq=1 id=7", irq, irqID); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++; if (irq !== 1'b0 || pending !== 8'h00) begin errors++; $display("FAIL prio_ack2 got irq=%b pend=%h want irq=0 pend=00", irq, pending); end
    endtask

    task automatic test_mask();
        do_reset();
        setMask = 1'b1; maskValue = 8'hFE;
        tick();
        setMask = 1'b0;
        irqIn = 8'h01;
        tick();
        irqIn = 8'h00;
        checks++; if (pending !== 8'h01) begin errors++; $display("FAIL mask_pending got %h want 01", pending); end
        tick(); tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_blocked got irq=%b want 0", irq); end
        setMask = 1'b1; maskValue = 8'hFF;
        tick();
        setMask = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_load_cycle got irq=%b want 0", irq); end
        tick();
        checks++; if (irq !== 1'b1 || irqID !== 3'd0) begin errors++; $display("FAIL mask_unmask got irq=%b id=%0d want irq=1 id=0", irq, irqID); end
        // Masking the active source must not retract it.
        setMask = 1'b1; maskValue = 8'h00;
        tick();
        setMask = 1'b0;
        checks++; if (irq !== 1'b1 || irqID !== 3'd0) begin errors++; $display("FAIL mask_in_assert got irq=%b id=%0d want irq=1 id=0", irq, irqID); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++; if (pending !== 8'h00 || irq !== 1'b0) begin errors++; $display("FAIL mask_ack got irq=%b pend=%h want irq=0 pend=00", irq, pending); end
    endtask

    task automatic test_set_wins();
        do_reset();
        irqIn = 8'h08;
        tick();
        tick();
        checks++; if (irq !== 1'b1 || irqID !== 3'd3) begin errors++; $display("FAIL setwin_assert got irq=%b id=%0d want irq=1 id=3", irq, irqID); end
        irqIn = 8'h00;
        tick();
        irqIn = 8'h08; ack = 1'b1;
        tick();
        irqIn = 8'h00; ack = 1'b0;
        checks++; if (pending !== 8'h08 || irq !== 1'b0) begin errors++; $display("FAIL setwin_ack got irq=%b pend=%h want irq=0 pend=08", irq, pending); end
        tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL setwin_holdoff got irq=%b want 0", irq); end
        tick();
        checks++; if (irq !== 1'b1 || irqID !== 3'd3) begin errors++; $display("FAIL setwin_reassert got irq=%b id=%0d want irq=1 id=3", irq, irqID); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL setwin_final got pend=%h want 00", pending); end
    endtask

    task automatic test_held_level();
        int   rises;
        logic last;
        do_reset();
        rises = 0;
        last  = 1'b0;
        irqIn = 8'h02;
        for (int c = 0; c < 20; c++) begin
            ack = (c == 5);
            tick();
            if (irq && !last) rises++;
            last = irq;
        end
        ack = 1'b0;
        irqIn = 8'h00;
        checks++; if (rises != 1) begin errors++; $display("FAIL held_count got %0d want 1", rises); end
        checks++; if (pending !== 8'h00 || irq !== 1'b0) begin errors++; $display("FAIL held_final got irq=%b pend=%h want irq=0 pend=00", irq, pending); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        checks++; if (pending !== 8'h00 || irq !== 1'b0) begin errors++; $display("FAIL stray_ack got irq=%b pend=%h want irq=0 pend=00", irq, pending); end
        // IDLE must still respond normally after the stray ack.
        irqIn = 8'h20;
        tick();
        irqIn = 8'h00;
        tick();
        checks++; if (irq !== 1'b1 || irqID !== 3'd5) begin errors++; $display("FAIL stray_after got irq=%b id=%0d want irq=1 id=5", irq, irqID); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        irqIn = 8'h06;
        tick();
        irqIn = 8'h00;
        tick();
        checks++; if (irq !== 1'b1 || irqID !== 3'd1 || pending !== 8'h06) begin errors++; $display("FAIL rstmid_pre got irq=%b id=%0d pend=%h want irq=1 id=1 pend=06", irq, irqID, pending); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (irq !== 1'b0 || pending !== 8'h00 || irqID !== 3'd0) begin errors++; $display("FAIL rstmid_clear got irq=%b id=%0d pend=%h want irq=0 id=0 pend=00", irq, irqID, pending); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (irq !== 1'b0 || pending !== 8'h00) begin errors++; $display("FAIL rstmid_quiet got irq=%b pend=%h want irq=0 pend=00 (cycle %0d)", irq, pending, i); end
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_mask();
        test_set_wins();
        test_held_level();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
